// File: rtl/etiket_ata.sv
// Tag-assignment skid stage: 2-entry FIFO of decoded micro-ops, tagged as they issue downstream.
// Latency: 1 cycle enqueue-to-output, no bypass. Backpressure: ready drops when both entries are held.
// Flush empties the FIFO but leaves the tag counter and issue count untouched.

module etiket_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         temizle,
  input  logic         yaz,
  input  logic [W-1:0] yaz_dat,
  input  logic         oku,
  output logic [W-1:0] oku_dat,
  output logic         dolu,
  output logic         bos
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] doluluk;

  function automatic logic [AW-1:0] sonraki(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      doluluk <= '0;
    end else if (temizle) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      doluluk <= '0;
    end else begin
      if (yaz) wr_ptr <= sonraki(wr_ptr);
      if (oku) rd_ptr <= sonraki(rd_ptr);
      if (yaz && !oku)      doluluk <= doluluk + 1'b1;
      else if (!yaz && oku) doluluk <= doluluk - 1'b1;
    end
  end

  // Payload storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk_i) begin
    if (yaz) mem[wr_ptr] <= yaz_dat;
  end

  assign oku_dat = mem[rd_ptr];
  assign dolu    = (doluluk == CW'(DEPTH));
  assign bos     = (doluluk == '0);
endmodule

module etiket_ata #(
  parameter int UOP_W = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             coz_gecerli_i,
  input  logic [UOP_W-1:0] coz_uop_i,
  output logic             coz_hazir_o,
  input  logic             bosalt_i,
  output logic             yo_gecerli_o,
  output logic [UOP_W-1:0] yo_uop_o,
  output logic [TAG_W-1:0] yo_etiket_o,
  input  logic             yo_duraklat_i,
  output logic [31:0]      verilen_sayac_o
);
  logic             yaz;
  logic             oku;
  logic             dolu;
  logic             bos;
  logic [TAG_W-1:0] etiket_r;
  logic [31:0]      sayac_r;

  // Ready/valid look only at registered occupancy and flush, never at the stall input.
  assign coz_hazir_o  = !dolu && !bosalt_i;
  assign yaz          = coz_gecerli_i && coz_hazir_o;
  assign yo_gecerli_o = !bos && !bosalt_i;
  assign oku          = yo_gecerli_o && !yo_duraklat_i;

  etiket_fifo #(
    .W     (UOP_W),
    .DEPTH (2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .temizle (bosalt_i),
    .yaz     (yaz),
    .yaz_dat (coz_uop_i),
    .oku     (oku),
    .oku_dat (yo_uop_o),
    .dolu    (dolu),
    .bos     (bos)
  );

  // Tag 0 is reserved, so the counter wraps from all-ones back to 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      etiket_r <= TAG_W'(1);
      sayac_r  <= '0;
    end else if (oku) begin
      etiket_r <= (etiket_r == '1) ? TAG_W'(1) : etiket_r + 1'b1;
      sayac_r  <= sayac_r + 32'd1;
    end
  end

  assign yo_etiket_o     = etiket_r;
  assign verilen_sayac_o = sayac_r;
endmodule

// File: tb/tb_etiket_ata.sv
module tb_etiket_ata;
  typedef logic [63:0] uop_t;
  localparam int TMAX = 15;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i = 1'b1;
  logic        coz_gecerli_i = 1'b0;
  uop_t        coz_uop_i = '0;
  logic        coz_hazir_o;
  logic        bosalt_i = 1'b0;
  logic        yo_gecerli_o;
  uop_t        yo_uop_o;
  logic [3:0]  yo_etiket_o;
  logic        yo_duraklat_i = 1'b0;
  logic [31:0] verilen_sayac_o;

  logic        w_gec = 1'b0;
  uop_t        w_uop = '0;
  logic        w_hazir;
  logic        w_fl = 1'b0;
  logic        w_gecerli;
  uop_t        w_uop_o;
  logic [1:0]  w_etiket;
  logic        w_dur = 1'b0;
  logic [31:0] w_sayac;

  etiket_ata #(.UOP_W(64), .TAG_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .coz_gecerli_i(coz_gecerli_i), .coz_uop_i(coz_uop_i), .coz_hazir_o(coz_hazir_o),
    .bosalt_i(bosalt_i),
    .yo_gecerli_o(yo_gecerli_o), .yo_uop_o(yo_uop_o), .yo_etiket_o(yo_etiket_o),
    .yo_duraklat_i(yo_duraklat_i), .verilen_sayac_o(verilen_sayac_o)
  );

  etiket_ata #(.UOP_W(64), .TAG_W(2)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i),
    .coz_gecerli_i(w_gec), .coz_uop_i(w_uop), .coz_hazir_o(w_hazir),
    .bosalt_i(w_fl),
    .yo_gecerli_o(w_gecerli), .yo_uop_o(w_uop_o), .yo_etiket_o(w_etiket),
    .yo_duraklat_i(w_dur), .verilen_sayac_o(w_sayac)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of buffered uops, tag and issue count.
  uop_t        m_q[$];
  int          m_tag;
  logic [31:0] m_cnt;
  uop_t        exp_uop[$];
  int          exp_tag[$];
  uop_t        obs_uop[$];
  int          obs_tag[$];
  uop_t        w_obs_uop[$];
  int          w_obs_tag[$];

  always @(negedge clk_i) begin
    if (!rst_i && yo_gecerli_o === 1'b1 && !yo_duraklat_i) begin
      obs_uop.push_back(yo_uop_o);
      obs_tag.push_back(int'(yo_etiket_o));
    end
    if (!rst_i && w_gecerli === 1'b1 && !w_dur) begin
      w_obs_uop.push_back(w_uop_o);
      w_obs_tag.push_back(int'(w_etiket));
    end
  end

  task automatic model_reset();
    m_q.delete(); exp_uop.delete(); exp_tag.delete();
    obs_uop.delete(); obs_tag.delete(); w_obs_uop.delete(); w_obs_tag.delete();
    m_tag = 1;
    m_cnt = '0;
  endtask

  task automatic set_in(input logic g, input uop_t u, input logic d, input logic f);
    coz_gecerli_i = g;
    coz_uop_i     = u;
    yo_duraklat_i = d;
    bosalt_i      = f;
  endtask

  // Advance one clock edge and apply the queue-level rules to the model.
  task automatic adv();
    bit pop, push;
    @(posedge clk_i);
    if (!rst_i) begin
      if (bosalt_i) m_q.delete();
      else begin
        pop  = (m_q.size() > 0) && !yo_duraklat_i;
        push = coz_gecerli_i && (m_q.size() < 2);
        if (pop) begin
          exp_uop.push_back(m_q.pop_front());
          exp_tag.push_back(m_tag);
          m_tag = m_tag % TMAX + 1;
          m_cnt = m_cnt + 1;
        end
        if (push) m_q.push_back(coz_uop_i);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set_in(0, '0, 0, 0);
    w_gec = 0; w_uop = '0; w_dur = 0; w_fl = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_in(0, '0, 0, 0);
    @(negedge clk_i);
    checks++;
    if (coz_hazir_o !== 1'b1 || yo_gecerli_o !== 1'b0 || yo_etiket_o !== 4'd1 || verilen_sayac_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: hazir=%b gecerli=%b tag=%0d cnt=%0d, expected 1 0 1 0",
               coz_hazir_o, yo_gecerli_o, yo_etiket_o, verilen_sayac_o);
    end
    bosalt_i = 1'b1;
    #1;
    checks++;
    if (coz_hazir_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_hazir: hazir=%b expected 0", coz_hazir_o);
    end
    bosalt_i = 1'b0;
    checks++;
    if (w_etiket !== 2'd1 || w_gecerli !== 1'b0) begin
      errors++;
      $display("FAIL reset_w: tag=%0d gecerli=%b expected 1 0", w_etiket, w_gecerli);
    end
    do_reset();
  endtask

  task automatic test_streaming();
    uop_t u[4];
    do_reset();
    for (int i = 0; i < 4; i++) u[i] = {$urandom, $urandom};
    for (int i = 0; i < 7; i++) begin
      set_in(i < 4, (i < 4) ? u[i] : '0, 0, 0);
      @(negedge clk_i);
      if (i == 0) begin
        checks++;
        if (yo_gecerli_o !== 1'b0 || coz_hazir_o !== 1'b1) begin
          errors++;
          $display("FAIL stream_first: gecerli=%b hazir=%b expected 0 1", yo_gecerli_o, coz_hazir_o);
        end
      end else if (i <= 4) begin
        checks++;
        if (yo_gecerli_o !== 1'b1 || yo_uop_o !== u[i-1] || yo_etiket_o !== 4'(i)) begin
          errors++;
          $display("FAIL stream_head%0d: gecerli=%b uop=%h tag=%0d expected 1 %h %0d",
                   i, yo_gecerli_o, yo_uop_o, yo_etiket_o, u[i-1], i);
        end
      end
      adv();
    end
    checks++;
    if (obs_uop.size() != 4) begin
      errors++;
      $display("FAIL stream_count: issued=%0d expected 4", obs_uop.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_uop[k] !== u[k] || obs_tag[k] != k + 1) begin
          errors++;
          $display("FAIL stream_issue%0d: uop=%h tag=%0d expected %h %0d", k, obs_uop[k], obs_tag[k], u[k], k + 1);
        end
      end
    end
    checks++;
    if (verilen_sayac_o !== 32'd4) begin
      errors++;
      $display("FAIL stream_sayac: cnt=%0d expected 4", verilen_sayac_o);
    end
  endtask

  task automatic test_stall();
    uop_t u[3];
    logic eh[8];
    do_reset();
    for (int i = 0; i < 3; i++) u[i] = {$urandom, $urandom};
    eh = '{1, 1, 0, 0, 0, 1, 1, 1};
    for (int c = 0; c < 8; c++) begin
      set_in(c < 6, (c < 2) ? u[c] : u[2], c < 4, 0);
      @(negedge clk_i);
      checks++;
      if (coz_hazir_o !== eh[c]) begin
        errors++;
        $display("FAIL stall_hazir_c%0d: hazir=%b expected %b", c, coz_hazir_o, eh[c]);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (yo_gecerli_o !== 1'b1 || yo_uop_o !== u[0] || yo_etiket_o !== 4'd1) begin
          errors++;
          $display("FAIL stall_hold_c%0d: gecerli=%b uop=%h tag=%0d expected 1 %h 1",
                   c, yo_gecerli_o, yo_uop_o, yo_etiket_o, u[0]);
        end
      end
      adv();
    end
    checks++;
    if (obs_uop.size() != 3) begin
      errors++;
      $display("FAIL stall_count: issued=%0d expected 3", obs_uop.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_uop[k] !== u[k] || obs_tag[k] != k + 1) begin
          errors++;
          $display("FAIL stall_issue%0d: uop=%h tag=%0d expected %h %0d", k, obs_uop[k], obs_tag[k], u[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_wrap();
    uop_t wu[5];
    do_reset();
    for (int i = 0; i < 5; i++) wu[i] = {$urandom, $urandom};
    for (int i = 0; i < 7; i++) begin
      w_gec = (i < 5);
      w_uop = (i < 5) ? wu[i] : '0;
      @(posedge clk_i);
      #1;
    end
    w_gec = 0;
    checks++;
    if (w_obs_tag.size() != 5) begin
      errors++;
      $display("FAIL wrap_count: issued=%0d expected 5", w_obs_tag.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (w_obs_tag[k] != k % 3 + 1 || w_obs_uop[k] !== wu[k]) begin
          errors++;
          $display("FAIL wrap_issue%0d: tag=%0d uop=%h expected %0d %h", k, w_obs_tag[k], w_obs_uop[k], k % 3 + 1, wu[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    uop_t a0, a1, x, y, z, w;
    do_reset();
    a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; x = {$urandom, $urandom};
    y = {$urandom, $urandom}; z = {$urandom, $urandom}; w = {$urandom, $urandom};
    set_in(1, a0, 0, 0); adv();
    set_in(1, a1, 0, 0); adv();
    set_in(0, '0, 0, 0); adv();
    set_in(1, x, 1, 0); adv();
    set_in(1, y, 1, 0); adv();
    set_in(1, z, 0, 1);
    @(negedge clk_i);
    checks++;
    if (yo_gecerli_o !== 1'b0 || coz_hazir_o !== 1'b0 || yo_etiket_o !== 4'd3) begin
      errors++;
      $display("FAIL flush_cycle: gecerli=%b hazir=%b tag=%0d expected 0 0 3", yo_gecerli_o, coz_hazir_o, yo_etiket_o);
    end
    adv();
    set_in(0, '0, 0, 0);
    @(negedge clk_i);
    checks++;
    if (yo_gecerli_o !== 1'b0 || coz_hazir_o !== 1'b1 || verilen_sayac_o !== 32'd2) begin
      errors++;
      $display("FAIL flush_after: gecerli=%b hazir=%b cnt=%0d expected 0 1 2", yo_gecerli_o, coz_hazir_o, verilen_sayac_o);
    end
    adv();
    set_in(1, w, 0, 0); adv();
    set_in(0, '0, 0, 0);
    @(negedge clk_i);
    checks++;
    if (yo_gecerli_o !== 1'b1 || yo_uop_o !== w || yo_etiket_o !== 4'd3) begin
      errors++;
      $display("FAIL flush_next: gecerli=%b uop=%h tag=%0d expected 1 %h 3", yo_gecerli_o, yo_uop_o, yo_etiket_o, w);
    end
    adv();
    checks++;
    if (obs_uop.size() != 3 || obs_uop[obs_uop.size()-1] !== w) begin
      errors++;
      $display("FAIL flush_issued: issued=%0d expected 3 ending with %h", obs_uop.size(), w);
    end
  endtask

  task automatic test_simul();
    uop_t p[9];
    do_reset();
    for (int i = 0; i < 9; i++) p[i] = {$urandom, $urandom};
    set_in(1, p[0], 0, 0); adv();
    for (int i = 1; i < 9; i++) begin
      set_in(1, p[i], 0, 0);
      @(negedge clk_i);
      checks++;
      if (coz_hazir_o !== 1'b1 || yo_gecerli_o !== 1'b1 || yo_uop_o !== p[i-1] || yo_etiket_o !== 4'(i)) begin
        errors++;
        $display("FAIL simul_c%0d: hazir=%b gecerli=%b uop=%h tag=%0d expected 1 1 %h %0d",
                 i, coz_hazir_o, yo_gecerli_o, yo_uop_o, yo_etiket_o, p[i-1], i);
      end
      adv();
    end
    set_in(0, '0, 0, 0); adv(); adv();
    checks++;
    if (obs_uop.size() != 9 || verilen_sayac_o !== 32'd9) begin
      errors++;
      $display("FAIL simul_count: issued=%0d cnt=%0d expected 9 9", obs_uop.size(), verilen_sayac_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(i < 4, {$urandom, $urandom}, 0, 0);
      adv();
    end
    set_in(1, {$urandom, $urandom}, 1, 0); adv();
    set_in(1, {$urandom, $urandom}, 1, 0); adv();
    set_in(1, {$urandom, $urandom}, 1, 0);
    @(negedge clk_i);
    checks++;
    if (coz_hazir_o !== 1'b0 || yo_gecerli_o !== 1'b1 || yo_etiket_o !== 4'd5) begin
      errors++;
      $display("FAIL arst_pre: hazir=%b gecerli=%b tag=%0d expected 0 1 5", coz_hazir_o, yo_gecerli_o, yo_etiket_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (yo_gecerli_o !== 1'b0 || yo_etiket_o !== 4'd1 || verilen_sayac_o !== 32'd0 || coz_hazir_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_immediate: gecerli=%b tag=%0d cnt=%0d hazir=%b expected 0 1 0 1",
               yo_gecerli_o, yo_etiket_o, verilen_sayac_o, coz_hazir_o);
    end
    set_in(0, '0, 0, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic eg, eh;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      @(negedge clk_i);
      eg = (m_q.size() > 0) && !bosalt_i;
      eh = (m_q.size() < 2) && !bosalt_i;
      checks++;
      if (yo_gecerli_o !== eg || coz_hazir_o !== eh) begin
        errors++;
        $display("FAIL rand_hs_c%0d: gecerli=%b hazir=%b expected %b %b", c, yo_gecerli_o, coz_hazir_o, eg, eh);
      end
      checks++;
      if ({28'd0, yo_etiket_o} !== m_tag || verilen_sayac_o !== m_cnt) begin
        errors++;
        $display("FAIL rand_tag_c%0d: tag=%0d cnt=%0d expected %0d %0d", c, yo_etiket_o, verilen_sayac_o, m_tag, m_cnt);
      end
      if (eg) begin
        checks++;
        if (yo_uop_o !== m_q[0]) begin
          errors++;
          $display("FAIL rand_uop_c%0d: uop=%h expected %h", c, yo_uop_o, m_q[0]);
        end
      end
      adv();
    end
    set_in(0, '0, 0, 0);
    repeat (3) adv();
    checks++;
    if (obs_uop.size() != exp_uop.size()) begin
      errors++;
      $display("FAIL rand_count: issued=%0d expected %0d", obs_uop.size(), exp_uop.size());
    end else begin
      for (int k = 0; k < exp_uop.size(); k++) begin
        checks++;
        if (obs_uop[k] !== exp_uop[k] || obs_tag[k] != exp_tag[k]) begin
          errors++;
          $display("FAIL rand_issue%0d: uop=%h tag=%0d expected %h %0d", k, obs_uop[k], obs_tag[k], exp_uop[k], exp_tag[k]);
          break;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_stall();
    test_wrap();
    test_flush();
    test_simul();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
